// File: rtl/i2c_target_responder_if.sv
// Bus and user-register signals of the I2C target responder, grouped for port connection.
interface i2c_target_responder_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       busy;

  // Target side: samples the pads, drives SDA pull-down and the register strobes.
  modport slave (
    input  scl_in, sda_in, rd_data,
    output sda_oe, wr_stb, wr_addr, wr_data, rd_addr, busy
  );

  // Initiator / user-logic side.
  modport master (
    output scl_in, sda_in, rd_data,
    input  sda_oe, wr_stb, wr_addr, wr_data, rd_addr, busy
  );
endinterface

// File: rtl/i2c_target_responder.sv
// I2C target: START/STOP decode, 7-bit address match, register pointer with
// auto-increment, byte writes to user logic and byte reads from user logic.
// SCL is oversampled on clk48; SDA is only ever changed on SCL falling edges.
module i2c_target_responder #(
  parameter logic [6:0] I2C_ADDR    = 7'h50,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                     clk48,
  input  logic                     rst_n,
  i2c_target_responder_if.slave    bus
);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_ADDR      = 4'd1,
    ST_ADDR_ACK  = 4'd2,
    ST_PTR       = 4'd3,
    ST_PTR_ACK   = 4'd4,
    ST_WDATA     = 4'd5,
    ST_WDATA_ACK = 4'd6,
    ST_RDATA     = 4'd7,
    ST_RDATA_ACK = 4'd8,
    ST_WAIT_STOP = 4'd9
  } state_t;

  logic [SYNC_STAGES-1:0] scl_sync_r;
  logic [SYNC_STAGES-1:0] sda_sync_r;
  logic                   scl_prev_r;
  logic                   sda_prev_r;

  state_t     state_r;
  logic [3:0] bit_cnt_r;
  logic [7:0] shift_r;
  logic [7:0] ptr_r;
  logic       rw_r;
  logic       sda_oe_r;
  logic       wr_stb_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic       busy_r;

  logic       scl_s;
  logic       sda_s;
  logic       scl_rise_s;
  logic       scl_fall_s;
  logic       start_s;
  logic       stop_s;
  logic [7:0] byte_in_s;
  logic       addr_match_s;

  assign scl_s        = scl_sync_r[SYNC_STAGES-1];
  assign sda_s        = sda_sync_r[SYNC_STAGES-1];
  assign scl_rise_s   = scl_s & ~scl_prev_r;
  assign scl_fall_s   = ~scl_s & scl_prev_r;
  // SDA transitions are only bus conditions while SCL stays high.
  assign start_s      = scl_s & scl_prev_r & sda_prev_r & ~sda_s;
  assign stop_s       = scl_s & scl_prev_r & ~sda_prev_r & sda_s;
  assign byte_in_s    = {shift_r[6:0], sda_s};
  assign addr_match_s = (shift_r[7:1] == I2C_ADDR);

  assign bus.sda_oe  = sda_oe_r;
  assign bus.wr_stb  = wr_stb_r;
  assign bus.wr_addr = wr_addr_r;
  assign bus.wr_data = wr_data_r;
  assign bus.rd_addr = ptr_r;
  assign bus.busy    = busy_r;

  // Synchronise the pad levels and keep the previous synchronised level for edge detection.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      scl_sync_r <= {SYNC_STAGES{1'b1}};
      sda_sync_r <= {SYNC_STAGES{1'b1}};
      scl_prev_r <= 1'b1;
      sda_prev_r <= 1'b1;
    end else begin
      scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], bus.scl_in};
      sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], bus.sda_in};
      scl_prev_r <= scl_s;
      sda_prev_r <= sda_s;
    end
  end

  // Protocol FSM: bit shifting, ACK generation, pointer handling and register strobes.
  always_ff @(posedge clk48 or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 4'd0;
      shift_r   <= 8'd0;
      ptr_r     <= 8'd0;
      rw_r      <= 1'b0;
      sda_oe_r  <= 1'b0;
      wr_stb_r  <= 1'b0;
      wr_addr_r <= 8'd0;
      wr_data_r <= 8'd0;
      busy_r    <= 1'b0;
    end else begin
      wr_stb_r <= 1'b0;
      if (start_s) begin
        // START or repeated START: any partial byte is dropped, pointer kept.
        state_r   <= ST_ADDR;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b1;
      end else if (stop_s) begin
        state_r   <= ST_IDLE;
        bit_cnt_r <= 4'd0;
        sda_oe_r  <= 1'b0;
        busy_r    <= 1'b0;
      end else begin
        case (state_r)
          ST_IDLE: begin
            sda_oe_r <= 1'b0;
          end
          ST_ADDR, ST_PTR, ST_WDATA: begin
            if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
              shift_r   <= byte_in_s;
              bit_cnt_r <= bit_cnt_r + 4'd1;
              if ((state_r == ST_WDATA) && (bit_cnt_r == 4'd7)) begin
                wr_stb_r  <= 1'b1;
                wr_addr_r <= ptr_r;
                wr_data_r <= byte_in_s;
              end
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              bit_cnt_r <= 4'd0;
              if (state_r == ST_ADDR) begin
                if (addr_match_s) begin
                  rw_r     <= shift_r[0];
                  sda_oe_r <= 1'b1;
                  state_r  <= ST_ADDR_ACK;
                end else begin
                  sda_oe_r <= 1'b0;
                  state_r  <= ST_WAIT_STOP;
                end
              end else if (state_r == ST_PTR) begin
                ptr_r    <= shift_r;
                sda_oe_r <= 1'b1;
                state_r  <= ST_PTR_ACK;
              end else begin
                ptr_r    <= ptr_r + 8'd1;
                sda_oe_r <= 1'b1;
                state_r  <= ST_WDATA_ACK;
              end
            end
          end
          ST_ADDR_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r <= 4'd0;
              if (rw_r) begin
                // First read bit goes out on the same edge that ends our ACK.
                shift_r  <= {bus.rd_data[6:0], 1'b0};
                sda_oe_r <= ~bus.rd_data[7];
                state_r  <= ST_RDATA;
              end else begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_PTR;
              end
            end
          end
          ST_PTR_ACK, ST_WDATA_ACK: begin
            if (scl_fall_s) begin
              bit_cnt_r <= 4'd0;
              sda_oe_r  <= 1'b0;
              state_r   <= ST_WDATA;
            end
          end
          ST_RDATA: begin
            if (scl_rise_s && (bit_cnt_r < 4'd8)) begin
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end else if (scl_fall_s && (bit_cnt_r == 4'd8)) begin
              bit_cnt_r <= 4'd0;
              sda_oe_r  <= 1'b0;
              state_r   <= ST_RDATA_ACK;
            end else if (scl_fall_s && (bit_cnt_r != 4'd0)) begin
              sda_oe_r <= ~shift_r[7];
              shift_r  <= {shift_r[6:0], 1'b0};
            end
          end
          ST_RDATA_ACK: begin
            if (scl_rise_s) begin
              if (sda_s) begin
                sda_oe_r <= 1'b0;
                state_r  <= ST_WAIT_STOP;
              end else begin
                ptr_r <= ptr_r + 8'd1;
              end
            end else if (scl_fall_s) begin
              // Only reached after an initiator ACK; rd_data already follows the new pointer.
              bit_cnt_r <= 4'd0;
              shift_r   <= {bus.rd_data[6:0], 1'b0};
              sda_oe_r  <= ~bus.rd_data[7];
              state_r   <= ST_RDATA;
            end
          end
          ST_WAIT_STOP: begin
            sda_oe_r <= 1'b0;
          end
          default: begin
            sda_oe_r <= 1'b0;
            state_r  <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule
